// File: rtl/arf_sched_pkg.sv
// Shared constants and datapath types for the ARF operator schedulers.
// Default sizing of the shared multiplier and its requester pool.
package arf_sched_pkg;

    localparam int N     = 4;
    localparam int W     = 16;
    localparam int LAT   = 2;
    localparam int TRUNC = 4;
    localparam int IDW   = $clog2(N);

    typedef logic [W-1:0]   operand_t;
    typedef logic [2*W-1:0] product_t;
    typedef logic [IDW-1:0] id_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request at or after the
// rotating pointer; the pointer moves past the winner whenever a grant is made.
module rr_arbiter #(
    parameter int N = 4,
    localparam int IDW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] grant_idx
);

    logic [IDW-1:0] ptr;
    logic [IDW:0]   slot;
    logic           found;

    // NOTE: every output of this block gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        slot      = '0;
        for (int k = 0; k < N; k++) begin
            // NOTE: blocking assignments here are deliberate; slot and found are
            // scratch values reused within the same evaluation of the loop.
            slot = {1'b0, ptr} + (IDW+1)'(k);
            if (slot >= (IDW+1)'(N)) begin
                slot = slot - (IDW+1)'(N);
            end
            if (!found && req[slot[IDW-1:0]]) begin
                found                  = 1'b1;
                grant[slot[IDW-1:0]]   = 1'b1;
                grant_idx              = slot[IDW-1:0];
            end
        end
    end

    // A grant is always a transfer, since ready is the grant itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (found) begin
            ptr <= (grant_idx == IDW'(N-1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/arf_mul_sched.sv
// Shares one pipelined W x W multiplier among N requesters: round-robin issue,
// optional operand truncation per requester, ID-tagged fixed-latency results.
module arf_mul_sched
    import arf_sched_pkg::*;
#(
    parameter int N     = arf_sched_pkg::N,
    parameter int W     = arf_sched_pkg::W,
    parameter int LAT   = arf_sched_pkg::LAT,
    parameter int TRUNC = arf_sched_pkg::TRUNC,
    localparam int IDW  = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req_valid,
    output logic [N-1:0]     req_ready,
    input  logic [N*W-1:0]   req_a,
    input  logic [N*W-1:0]   req_b,
    input  logic [N-1:0]     req_approx,
    output logic             res_valid,
    output logic [IDW-1:0]   res_id,
    output logic [2*W-1:0]   res_data,
    output logic [15:0]      issue_cnt
);

    localparam logic [W-1:0] TRUNC_MASK = {W{1'b1}} << TRUNC;

    logic [N-1:0]   grant;
    logic [IDW-1:0] grant_idx;
    logic           fire;
    logic [W-1:0]   op_a;
    logic [W-1:0]   op_b;
    logic [2*W-1:0] prod;

    rr_arbiter #(.N(N)) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req_valid),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign req_ready = grant;
    assign fire      = |grant;

    always_comb begin
        op_a = req_a[grant_idx*W +: W];
        op_b = req_b[grant_idx*W +: W];
        if (req_approx[grant_idx]) begin
            op_a = op_a & TRUNC_MASK;
            op_b = op_b & TRUNC_MASK;
        end
        prod = {{W{1'b0}}, op_a} * {{W{1'b0}}, op_b};
    end

    logic [LAT-1:0] pipe_valid;
    logic [IDW-1:0] pipe_id   [LAT];
    logic [2*W-1:0] pipe_data [LAT];

    // NOTE: the id/data stages are reset as well because their reset value is
    // visible on res_id/res_data; stages otherwise only load behind a valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_valid <= '0;
            for (int s = 0; s < LAT; s++) begin
                pipe_id[s]   <= '0;
                pipe_data[s] <= '0;
            end
        end else begin
            pipe_valid[0] <= fire;
            if (fire) begin
                pipe_id[0]   <= grant_idx;
                pipe_data[0] <= prod;
            end
            for (int s = 1; s < LAT; s++) begin
                pipe_valid[s] <= pipe_valid[s-1];
                if (pipe_valid[s-1]) begin
                    pipe_id[s]   <= pipe_id[s-1];
                    pipe_data[s] <= pipe_data[s-1];
                end
            end
        end
    end

    assign res_valid = pipe_valid[LAT-1];
    assign res_id    = pipe_id[LAT-1];
    assign res_data  = pipe_data[LAT-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_cnt <= '0;
        end else if (fire) begin
            issue_cnt <= issue_cnt + 16'd1;
        end
    end

endmodule
